pack_str_gather: RTL and testbench

Upstream stage for the module-port demonstration block. It accepts a serial stream of `pack_str_t` elements (fields `a`, `b`) over a valid/ready handshake. It assembles them into frames of up to N elements and presents each frame in the port shapes the consumer expects: an unpacked array of structs, a packed vector, and an unpacked bit array. A two-deep arrangement (assembly buffer plus output register) sustains one element per cycle under continuous downstream readiness.

---
 rtl/pack_str_gather_if.sv | 41 ++++
 rtl/pack_str_gather.sv | 108 ++++++++++
 tb/tb_pack_str_gather.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pack_str_gather_if.sv
// pack_str_pkg / pack_str_gather_if
//   Element type and the handshake bundle for pack_str_gather.
//   Upstream side : in_valid, in_ready, in_data, in_last
//   Downstream side: out_valid, out_ready, out_pack_str, out_pack,
//                    out_unpack, out_len
//   Modports: master = stream producer / frame consumer (testbench side),
//             slave  = the gather block itself.
package pack_str_pkg;
    typedef struct packed {
        logic a;
        logic b;
    } pack_str_t;
endpackage

interface pack_str_gather_if #(
    parameter int N = 3
) ();
    localparam int LW = $clog2(N + 1);

    logic                  in_valid;
    logic                  in_ready;
    pack_str_pkg::pack_str_t in_data;
    logic                  in_last;

    logic                  out_valid;
    logic                  out_ready;
    pack_str_pkg::pack_str_t out_pack_str [N-1:0];
    logic [N-1:0]          out_pack;
    logic                  out_unpack   [N-1:0];
    logic [LW-1:0]         out_len;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_pack_str, out_pack, out_unpack, out_len
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_pack_str, out_pack, out_unpack, out_len
    );
endinterface

// File: rtl/pack_str_gather.sv
// pack_str_gather
//   Collects a serial stream of pack_str_t elements into frames of up to N
//   elements and presents each frame as an unpacked struct array, a packed
//   vector of the 'a' fields and an unpacked array of the 'b' fields.
//   Ports:
//     clk  - clock, all state on rising edge
//     rst  - asynchronous active-high reset
//     bus  - pack_str_gather_if.slave (input stream + frame output)
//   An assembly buffer plus the output register form a two-deep pipe, so a
//   frame can complete while the previous one is still being presented.
module pack_str_gather #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst,
    pack_str_gather_if.slave bus
);
    import pack_str_pkg::*;

    localparam int LW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [LW-1:0] r_alen;
    pack_str_t     r_asm [N-1:0];
    pack_str_t     r_out [N-1:0];
    logic [LW-1:0] r_out_len;
    logic          r_out_valid;

    logic w_free;
    logic w_beat;
    logic w_complete;

    // in_ready decodes from state only: no path from in_valid/out_ready.
    assign bus.in_ready = (r_state == COLLECT);
    assign w_free       = !r_out_valid || bus.out_ready;
    assign w_beat       = bus.in_valid && (r_state == COLLECT);
    assign w_complete   = w_beat && ((r_idx == IW'(N - 1)) || bus.in_last);

    assign bus.out_valid = r_out_valid;
    assign bus.out_len   = r_out_len;

    for (genvar k = 0; k < N; k++) begin : g_proj
        assign bus.out_pack_str[k] = r_out[k];
        assign bus.out_pack[k]     = r_out[k].a;
        assign bus.out_unpack[k]   = r_out[k].b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_idx       <= '0;
            r_alen      <= '0;
            r_out_len   <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_asm[k] <= '0;
                r_out[k] <= '0;
            end
        end else begin
            // Consumer took the frame; a load below overrides this clear.
            if (r_out_valid && bus.out_ready)
                r_out_valid <= 1'b0;

            case (r_state)
                COLLECT: begin
                    if (w_beat && !w_complete) begin
                        r_asm[r_idx] <= bus.in_data;
                        r_idx        <= r_idx + 1'b1;
                    end else if (w_complete && w_free) begin
                        // Bypass the buffer: last element goes straight out.
                        // Slots above idx are zeroed so stale asm never leaks.
                        for (int k = 0; k < N; k++) begin
                            if (IW'(k) < r_idx)
                                r_out[k] <= r_asm[k];
                            else if (IW'(k) == r_idx)
                                r_out[k] <= bus.in_data;
                            else
                                r_out[k] <= '0;
                        end
                        r_out_len   <= LW'(r_idx) + LW'(1);
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                    end else if (w_complete) begin
                        // Output busy: park the completed frame in asm.
                        r_asm[r_idx] <= bus.in_data;
                        r_alen       <= LW'(r_idx) + LW'(1);
                        r_idx        <= '0;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_free) begin
                        for (int k = 0; k < N; k++)
                            r_out[k] <= (LW'(k) < r_alen) ? r_asm[k] : '0;
                        r_out_len   <= r_alen;
                        r_out_valid <= 1'b1;
                        r_state     <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_pack_str_gather.sv
module tb_pack_str_gather;
    import pack_str_pkg::*;

    localparam int N = 3;

    typedef struct {
        logic [2*N-1:0] v;
        int             len;
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    pack_str_t part  [$];
    frame_t    exp_q [$];

    pack_str_gather_if #(.N(N)) bus ();

    pack_str_gather #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: list of accepted elements, cut into frames at N or in_last.
    always @(negedge clk) begin
        frame_t f;
        if (rst) begin
            part.delete();
            exp_q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            part.push_back(bus.in_data);
            if (part.size() == N || bus.in_last) begin
                f.v = '0;
                foreach (part[k]) f.v[2*k +: 2] = part[k];
                f.len = part.size();
                exp_q.push_back(f);
                part.delete();
            end
        end
    end

    // Monitor: per-cycle output invariants plus scoreboard on each transfer.
    logic [2*N-1:0] snap;
    int             slen;
    bit             held = 0;

    always @(negedge clk) begin
        logic [2*N-1:0] av;
        frame_t         f;
        if (rst) begin
            held = 0;
        end else if (bus.out_valid) begin
            av = '0;
            for (int k = 0; k < N; k++) begin
                av[2*k +: 2] = bus.out_pack_str[k];
                chk("proj_pack",   int'(bus.out_pack[k]),   int'(bus.out_pack_str[k].a));
                chk("proj_unpack", int'(bus.out_unpack[k]), int'(bus.out_pack_str[k].b));
                if (k >= int'(bus.out_len))
                    chk("zero_fill", int'(av[2*k +: 2]), 0);
            end
            chk("len_range", int'(bus.out_len >= 1 && bus.out_len <= N), 1);
            if (held) begin
                chk("stable_data", int'(av), int'(snap));
                chk("stable_len",  int'(bus.out_len), slen);
            end
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_frame: got data %0h len %0d, expected none", av, bus.out_len);
                end else begin
                    f = exp_q.pop_front();
                    chk("frame_data", int'(av), int'(f.v));
                    chk("frame_len",  int'(bus.out_len), f.len);
                end
                held = 0;
            end else begin
                held = 1;
                snap = av;
                slen = int'(bus.out_len);
            end
        end else begin
            if (held) chk("valid_dropped", 0, 1);
            held = 0;
        end
    end

    // Called aligned to posedge+1; returns posedge+1 after the accepting edge.
    task automatic send(input logic a, input logic b, input logic last);
        int t = 0;
        bit r;
        bus.in_valid = 1'b1;
        bus.in_data  = {a, b};
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            t++;
            if (t > 100) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unpack_vec();
        int v = 0;
        for (int k = 0; k < N; k++) v |= int'(bus.out_unpack[k]) << k;
        return v;
    endfunction

    initial begin
        logic [1:0] d [6];
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        step();
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready",  int'(bus.in_ready), 1);
        chk("rst_out_len",   int'(bus.out_len), 0);
        chk("rst_out_pack",  int'(bus.out_pack), 0);
        rst = 1'b0;

        // Basic full frame
        bus.out_ready = 1'b1;
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        chk("t1_not_yet_valid", int'(bus.out_valid), 0);
        send(1'b1, 1'b1, 1'b0);
        chk("t1_valid",  int'(bus.out_valid), 1);
        chk("t1_pack",   int'(bus.out_pack), 3'b101);
        chk("t1_unpack", unpack_vec(), 3'b110);
        chk("t1_len",    int'(bus.out_len), 3);

        // Early close with in_last
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        chk("t2_len",   int'(bus.out_len), 2);
        chk("t2_slot2", int'(bus.out_pack_str[2]), 0);
        chk("t2_pack",  int'(bus.out_pack), 3'b011);
        step();

        // Backpressure: two frames, second parks in HOLD
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d[i] = 2'($urandom);
            send(d[i][1], d[i][0], 1'b0);
        end
        chk("t3_in_ready_hold", int'(bus.in_ready), 0);
        chk("t3_f1_valid",      int'(bus.out_valid), 1);
        chk("t3_f1_pack",       int'(bus.out_pack), int'({d[2][1], d[1][1], d[0][1]}));
        repeat (3) step();
        chk("t3_in_ready_still", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t3_f2_valid",   int'(bus.out_valid), 1);
        chk("t3_f2_pack",    int'(bus.out_pack), int'({d[5][1], d[4][1], d[3][1]}));
        chk("t3_f2_unpack",  unpack_vec(), int'({d[5][0], d[4][0], d[3][0]}));
        chk("t3_in_ready_back", int'(bus.in_ready), 1);
        step();
        chk("t3_f2_stable", int'(bus.out_pack), int'({d[5][1], d[4][1], d[3][1]}));
        bus.out_ready = 1'b1;
        step();

        // Single-element frames, continuous
        for (int i = 0; i < 6; i++) begin
            d[i] = 2'($urandom);
            send(d[i][1], d[i][0], 1'b1);
            chk("t4_valid", int'(bus.out_valid), 1);
            chk("t4_len",   int'(bus.out_len), 1);
            chk("t4_a",     int'(bus.out_pack[0]), int'(d[i][1]));
            chk("t4_b",     int'(bus.out_unpack[0]), int'(d[i][0]));
        end
        step();

        // Async reset mid-frame while a frame is presented
        bus.out_ready = 1'b0;
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid",    int'(bus.out_valid), 0);
        chk("t5_rst_pack",     int'(bus.out_pack), 0);
        chk("t5_rst_unpack",   unpack_vec(), 0);
        chk("t5_rst_len",      int'(bus.out_len), 0);
        chk("t5_rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        step();
        bus.out_ready = 1'b1;
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        chk("t5_len",    int'(bus.out_len), 3);
        chk("t5_pack",   int'(bus.out_pack), 3'b010);
        chk("t5_unpack", unpack_vec(), 3'b001);
        step();

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_data   = 2'($urandom);
            bus.in_last   = ($urandom % 4) == 0;
            bus.out_ready = ($urandom % 3) != 0;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        send(1'b0, 1'b0, 1'b1);
        repeat (5) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
